// File: rtl/linebuf_window_ctrl.sv
// Line-buffer window controller: counts incoming pixels, strobes the line buffer and
// flags full KERNEL_W x (NUM_LINES+1) windows. Optional row-length checker: LBCTRL_ROW_CHECK_EN.
module linebuf_window_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int NUM_LINES    = 2,
  parameter int KERNEL_W     = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_sof,
  input  logic                            s_eol,
  input  logic                            m_ready,
  output logic                            lb_wr_en,
  output logic                            win_valid,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  win_col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] win_row,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            err
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  // Pixel width only matters to the line buffer datapath.
  localparam int unused_dw = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            win_valid_q, win_valid_d;
  logic [CW-1:0]   win_col_q, win_col_d;
  logic [RW-1:0]   win_row_q, win_row_d;

  logic accept, sof_acc, cnt_acc, col_last, row_last;

  assign accept   = s_valid & s_ready;
  assign sof_acc  = accept & s_sof;
  assign cnt_acc  = accept & ~s_sof & ((state_q == PRIME) | (state_q == STREAM));
  assign col_last = (col_q == CW'(IMAGE_WIDTH - 1));
  assign row_last = (row_q == RW'(IMAGE_HEIGHT - 1));
  assign lb_wr_en = accept & ((state_q == PRIME) | (state_q == STREAM) | s_sof);

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE, PRIME: s_ready = 1'b1;
      STREAM:      s_ready = ~(win_valid_q & ~m_ready);
      default:     s_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;

    if (win_valid_q && m_ready) win_valid_d = 1'b0;
    if (state_q == DONE) state_d = IDLE;

    // The sof pixel itself occupies column 0, so counting resumes at column 1.
    if (sof_acc) begin
      state_d     = PRIME;
      col_d       = CW'(1);
      row_d       = '0;
      win_valid_d = 1'b0;
    end else if (cnt_acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (state_q == PRIME && col_last && row_q == RW'(NUM_LINES - 1))
        state_d = STREAM;
      if (state_q == STREAM) begin
        if (col_q >= CW'(KERNEL_W - 1)) begin
          win_valid_d = 1'b1;
          win_col_d   = col_q;
          win_row_d   = row_q;
        end
        if (col_last && row_last) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_col    = win_col_q;
  assign win_row    = win_row_q;
  assign frame_done = (state_q == DONE);
  assign busy       = (state_q != IDLE);

`ifdef LBCTRL_ROW_CHECK_EN
  logic err_q, err_d;

  // s_eol must coincide exactly with the last column of every counted pixel.
  always_comb begin
    err_d = err_q;
    if (sof_acc)                           err_d = 1'b0;
    else if (cnt_acc && (s_eol != col_last)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_eol;
  assign unused_eol = s_eol;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Directed bench for linebuf_window_ctrl on an 8x4 frame, 3-wide window over 2 held lines.
module tb_linebuf_window_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
  logic       s_ready, lb_wr_en, win_valid, frame_done, busy, err;
  logic [2:0] win_col;
  logic [1:0] win_row;
  int n_chk = 0, n_fail = 0;

`ifdef LBCTRL_ROW_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  linebuf_window_ctrl #(.DATA_WIDTH(8), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(4),
                        .NUM_LINES(2), .KERNEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_eol(s_eol), .m_ready(m_ready), .lb_wr_en(lb_wr_en), .win_valid(win_valid),
    .win_col(win_col), .win_row(win_row), .frame_done(frame_done), .busy(busy), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer pixel p (frame index) for one cycle; expected window derives from p.
  task automatic push(input int p, input bit sof, input bit eol, input bit exp_wr);
    bit exp_wv;
    s_valid = 1'b1; s_sof = sof; s_eol = eol;
    #1;
    chk("s_ready", s_ready, 1);
    chk("lb_wr_en", lb_wr_en, exp_wr);
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    exp_wv = exp_wr && (p / 8 >= 2) && (p % 8 >= 2);
    chk("win_valid", win_valid, exp_wv);
    if (exp_wv) begin
      chk("win_col", win_col, p % 8);
      chk("win_row", win_row, p / 8);
    end
    chk("frame_done", frame_done, exp_wr && p == 31);
    chk("busy", busy, exp_wr);
  endtask

  task automatic run_px(input int from, input int to);
    for (int p = from; p <= to; p++) push(p, p == 0, p % 8 == 7, 1'b1);
  endtask

  task automatic finish_frame();
    chk("s_ready_done", s_ready, 0);
    @(posedge clk); #1;
    chk("frame_done_clr", frame_done, 0);
    chk("busy_idle", busy, 0);
    chk("win_valid_idle", win_valid, 0);
    chk("s_ready_idle", s_ready, 1);
    chk("err_clean", err, 0);
  endtask

  initial begin
    // reset values
    #2;
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // full frame back-to-back
    run_px(0, 31);
    finish_frame();

    // downstream stall at window (row 2, col 4)
    run_px(0, 20);
    m_ready = 1'b0; s_valid = 1'b1; s_eol = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_s_ready", s_ready, 0);
      chk("stall_lb_wr_en", lb_wr_en, 0);
      @(posedge clk); #1;
      chk("stall_win_valid", win_valid, 1);
      chk("stall_win_col", win_col, 4);
      chk("stall_win_row", win_row, 2);
    end
    m_ready = 1'b1;
    run_px(21, 31);
    finish_frame();

    // sof reasserted at row 1, col 5
    run_px(0, 12);
    push(0, 1'b1, 1'b0, 1'b1);
    run_px(1, 31);
    finish_frame();

    // reset mid-frame at row 3, col 3
    run_px(0, 26);
    s_valid = 1'b1; s_eol = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_win_valid", win_valid, 0);
    chk("arst_win_col", win_col, 0);
    chk("arst_win_row", win_row, 0);
    chk("arst_frame_done", frame_done, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_lb_wr_en", lb_wr_en, 0);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    // non-sof pixels in IDLE are dropped
    for (int p = 0; p < 3; p++) push(p, 1'b0, 1'b0, 1'b0);

    // early s_eol at col 5
    run_px(0, 4);
    push(5, 1'b0, 1'b1, 1'b1);
    chk("err_set", err, ERR_EN);
    push(6, 1'b0, 1'b0, 1'b1);
    push(7, 1'b0, 1'b1, 1'b1);
    chk("err_sticky", err, ERR_EN);
    push(0, 1'b1, 1'b0, 1'b1);
    chk("err_clr_sof", err, 0);
    run_px(1, 31);
    finish_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/linebuf_window_ctrl.md
LINEBUF_WINDOW_CTRL -- requirements
Module: linebuf_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width (passed through to the line buffer instance, unused internally).
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, pixels per row.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 480, rows per frame.
REQ-004 SHALL have parameter NUM_LINES, default 2, previous rows held by the line buffer.
REQ-005 SHALL have parameter KERNEL_W, default 3, window width in columns.
REQ-006 SHALL have port clk  input  1  the single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port s_valid  input  1  upstream pixel valid.
REQ-009 SHALL have port s_ready  output  1  controller accepts pixel.
REQ-010 SHALL have port s_sof  input  1  start of frame, qualified with the first pixel.
REQ-011 SHALL have port s_eol  input  1  last pixel of row, qualified with s_valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts window.
REQ-013 SHALL have port lb_wr_en  output  1  pixel_valid strobe to the line buffer.
REQ-014 SHALL have port win_valid  output  1  full KERNEL_W x (NUM_LINES+1) window available.
REQ-015 SHALL have port win_col  output  $clog2(IMAGE_WIDTH)  column of the newest pixel in the window.
REQ-016 SHALL have port win_row  output  $clog2(IMAGE_HEIGHT)  row of the newest pixel in the window.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-018 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-019 SHALL have port err  output  1  sticky row-length error flag.

Function
REQ-020 SHALL define accept = s_valid & s_ready; SHALL drive lb_wr_en = accept & (state is PRIME or STREAM, or s_sof) combinationally.
REQ-021 SHALL implement states IDLE, PRIME, STREAM, DONE.
REQ-022 SHALL transition IDLE->PRIME on accept with s_sof; SHALL drop non-sof pixels in IDLE (s_ready=1, lb_wr_en=0).
REQ-023 SHALL keep col/row counters: col increments on each written pixel and wraps from IMAGE_WIDTH-1 to 0 while incrementing row.
REQ-024 SHALL move PRIME->STREAM when row wraps into row NUM_LINES.
REQ-025 SHALL move STREAM->DONE on accept at col=IMAGE_WIDTH-1, row=IMAGE_HEIGHT-1; DONE SHALL last one cycle, pulse frame_done, then enter IDLE.
REQ-026 SHALL drive s_ready=1 in IDLE and PRIME, =0 in DONE, and =!(win_valid & !m_ready) in STREAM.
REQ-027 SHALL register win_valid one cycle after a STREAM accept with col>=KERNEL_W-1, matching the line buffer's one-cycle registered read latency.
REQ-028 SHALL hold win_valid, win_col, win_row stable while win_valid & !m_ready, and clear win_valid after a handshake with no new qualifying accept.
REQ-029 SHALL restart on accept with s_sof in any state: counters to col=1,row=0, state PRIME, pending win_valid cleared.
REQ-030 SHALL ignore s_eol for counting; row length is IMAGE_WIDTH exactly.

Reset
REQ-031 SHALL on rst_n low asynchronously set state IDLE, col=0, row=0, win_valid=0, win_col=0, win_row=0, frame_done=0, err=0, busy=0.
REQ-032 SHALL, on reset mid-frame, discard the frame; the next frame SHALL begin only with s_sof.

Configuration
REQ-033 SHALL, with macro LBCTRL_ROW_CHECK_EN defined, set err when an accepted pixel has s_eol=1 at col!=IMAGE_WIDTH-1 or s_eol=0 at col=IMAGE_WIDTH-1, holding err until an accept with s_sof or reset.
REQ-034 SHALL, without LBCTRL_ROW_CHECK_EN, tie err to 0 and contain no checking logic.

Verification (IMAGE_WIDTH=8, IMAGE_HEIGHT=4, NUM_LINES=2, KERNEL_W=3)
REQ-035 SHALL check: 32 back-to-back pixels, sof on first, m_ready=1 -> 12 win_valid pulses (rows 2-3, cols 2-7), frame_done one cycle after pixel 32.
REQ-036 SHALL check: m_ready=0 for 5 cycles at win (row 2, col 4) -> s_ready=0, lb_wr_en=0, window held 5 cycles, no pixel lost.
REQ-037 SHALL check: 3 pixels without sof in IDLE -> lb_wr_en stays 0, busy=0.
REQ-038 SHALL check: sof reasserted at row 1, col 5 -> state PRIME, first win_valid at row 2, col 2 of the new frame.
REQ-039 SHALL check: rst_n low at row 3, col 3 -> all outputs zero immediately, IDLE after release.
REQ-040 SHALL check: with LBCTRL_ROW_CHECK_EN, s_eol at col 5 -> err=1 until next sof; without the macro -> err=0.
